cdc_rx_buf: RTL and testbench
=============================

// Module: cdc_rx_buf
// PURPOSE
//  Receive side of a 4-phase req/ack clock-domain crossing, with a DEPTH-entry FWFT FIFO on the output.
//  Each request is acknowledged as soon as FIFO space exists, so the tx side keeps transferring
//  while the local consumer stalls. Sits in the DM/DTM clock domain; drives a valid/ready consumer.
// PARAMETERS
//  DW       32  data width, >=1
//  SYNC_DP  2   synchroniser depth on i_vld, >=2
//  DEPTH    4   FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1                 clock; the only clock
//  rst_n      in   1                 reset, asynchronous, active-low
//  i_vld      in   1                 4-phase request from the tx domain (asynchronous)
//  i_rdy      out  1                 4-phase acknowledge to the tx domain
//  i_dat      in   DW                tx data; stable while i_vld=1
//  o_vld      out  1                 FIFO not empty
//  o_rdy      in   1                 consumer ready
//  o_dat      out  DW                FIFO head entry (first-word fall-through)
//  o_count    out  $clog2(DEPTH+1)   current occupancy
//  proto_err  out  1                 sticky protocol error (only with CDC_RX_BUF_PROTO_CHK_EN)
// BEHAVIOUR
//  Reset: i_rdy=0, o_vld=0, o_dat=0, o_count=0, proto_err=0; sync chain, pointers and FIFO storage cleared.
//  Sync chain s[SYNC_DP:0]:
//   - each clk: s <= {i_vld, s[SYNC_DP:1]}
//   - vld_s=s[1], vld_p=s[0], nedge = ~vld_s & vld_p
//  Ack FSM (state is the i_rdy register):
//   - IDLE (i_rdy=0) -> ACK when push = vld_s & (o_count<DEPTH).
//     On that edge: i_dat written at wr_ptr, wr_ptr+1 mod DEPTH, i_rdy<=1.
//   - ACK (i_rdy=1) -> IDLE on nedge. vld_s is ignored while in ACK.
//   - Full (o_count==DEPTH) while vld_s=1: remain in IDLE with i_rdy=0. Push on the first edge after o_count<DEPTH.
//   - The full check uses the registered o_count. There is no same-cycle pop-to-push bypass.
//  Latency:
//   - i_vld rise to i_rdy=1 (FIFO not full): SYNC_DP+1 clk edges.
//   - o_vld and o_count update on the same edge as i_rdy.
//   - i_vld fall to i_rdy=0: SYNC_DP+1 clk edges.
//  Output:
//   - o_vld = (o_count!=0); o_dat = mem[rd_ptr], valid whenever o_vld=1.
//   - pop = o_vld & o_rdy; rd_ptr+1 mod DEPTH.
//   - o_rdy while empty: ignored.
//  Occupancy: push & pop in the same cycle -> o_count unchanged. Push only -> +1. Pop only -> -1. Never exceeds DEPTH, never underflows.
//  Pointers: $clog2(DEPTH) bits, wrap naturally; full/empty decided from o_count only.
//  Reset mid-operation:
//   - FIFO contents discarded; i_rdy drops immediately.
//   - If i_vld is still high after release, it is seen as a new request and re-captured after SYNC_DP+1 edges.
// CONFIGURATION
//  `CDC_RX_BUF_PROTO_CHK_EN defined:
//   - proto_err port present.
//   - Set to 1 on the edge where nedge=1 while i_rdy=0 (request withdrawn before ack).
//   - Stays 1 until rst_n. The offending request is not pushed.
//  Not defined:
//   - proto_err port absent; no error logic.
//   - nedge while i_rdy=0 is ignored; FIFO and FSM behave identically.
// TESTING
//  1 Single transfer, SYNC_DP=2, o_rdy=1: i_vld=1, i_dat=0xA5A5_0001 ->
//    i_rdy=1 and o_vld=1 with o_dat=0xA5A5_0001 3 edges later; pop next edge; i_rdy=0 3 edges after i_vld falls.
//  2 Back-pressure, DEPTH=4, o_rdy=0: 5 handshakes with data 1..5 ->
//    first 4 acked, o_count=4; 5th i_vld held with i_rdy=0.
//    One pop -> o_dat=2, 5th acked on the next edge, o_count back to 4.
//  3 Simultaneous push/pop: o_count=2 with o_rdy=1 on the push edge -> o_count stays 2; order 1,2,3 preserved.
//  4 Wrap-around: 10 transfers with a random o_rdy pattern -> output sequence 1..10 in order; o_count never >4 or <0.
//  5 Reset mid-transfer: o_count=3, i_rdy=1, assert rst_n=0 ->
//    all outputs 0 asynchronously; i_vld still high at release -> i_dat re-captured after 3 edges, o_count=1.
//  6 With CDC_RX_BUF_PROTO_CHK_EN and the FIFO full: pulse i_vld high 4 cycles then low ->
//    proto_err=1 and stays 1; o_count unchanged. Same stimulus without the macro -> no error, identical FIFO state.

Source files
------------

// File: rtl/cdc_rx_buf.sv
// Receive side of a 4-phase req/ack crossing feeding a first-word-fall-through FIFO.
// Optional sticky protocol checker enabled by defining CDC_RX_BUF_PROTO_CHK_EN.
module cdc_rx_buf #(
  parameter int DW      = 32,
  parameter int SYNC_DP = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [DW-1:0]              i_dat,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [DW-1:0]              o_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
`ifdef CDC_RX_BUF_PROTO_CHK_EN
  ,
  output logic                       proto_err
`endif
);

  // state | meaning
  // IDLE  | waiting for a synchronised request and FIFO space (i_rdy=0)
  // ACK   | request captured, holding ack until the request falls (i_rdy=1)
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SYNC_DP:0] sync_q, sync_d;
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic vld_s, vld_p, nedge;
  logic full, push, pop;

  assign sync_d = {i_vld, sync_q[SYNC_DP:1]};
  assign vld_s  = sync_q[1];
  assign vld_p  = sync_q[0];
  assign nedge  = ~vld_s & vld_p;

  // Full is judged on the registered count; a pop this cycle does not free space until next edge.
  assign full = (count_q == FULL_CNT);
  assign push = (state_q == IDLE) & vld_s & ~full;
  assign pop  = o_vld & o_rdy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push)  state_d = ACK;
      ACK:     if (nedge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= i_dat;
    end
  end

  assign i_rdy   = (state_q == ACK);
  assign o_vld   = (count_q != '0);
  assign o_dat   = mem_q[rd_ptr_q];
  assign o_count = count_q;

`ifdef CDC_RX_BUF_PROTO_CHK_EN
  // A falling request that was never acked means the tx side withdrew it.
  logic err_q, err_d;

  assign err_d = err_q | (nedge & (state_q == IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign proto_err = err_q;
`endif

endmodule

// File: tb/tb_cdc_rx_buf.sv
// Directed bench for cdc_rx_buf with default parameters (DW=32, SYNC_DP=2, DEPTH=4).
// Build with CDC_RX_BUF_PROTO_CHK_EN defined to also exercise the protocol checker.
module tb_cdc_rx_buf;

  logic        clk;
  logic        rst_n;
  logic        i_vld;
  logic        i_rdy;
  logic [31:0] i_dat;
  logic        o_vld;
  logic        o_rdy;
  logic [31:0] o_dat;
  logic [2:0]  o_count;
`ifdef CDC_RX_BUF_PROTO_CHK_EN
  logic        proto_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_d;

  cdc_rx_buf #(.DW(32), .SYNC_DP(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_vld     (i_vld),
    .i_rdy     (i_rdy),
    .i_dat     (i_dat),
    .o_vld     (o_vld),
    .o_rdy     (o_rdy),
    .o_dat     (o_dat),
    .o_count   (o_count)
`ifdef CDC_RX_BUF_PROTO_CHK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input logic lvl, input string tag);
    int n = 0;
    while (i_rdy !== lvl && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, i_rdy}, {63'd0, lvl});
  endtask

  task automatic handshake(input logic [31:0] d);
    i_dat = d;
    i_vld = 1'b1;
    wait_rdy(1'b1, "hs_ack_rise");
    i_vld = 1'b0;
    wait_rdy(1'b0, "hs_ack_fall");
  endtask

  task automatic drain_one(input logic [31:0] d, input string tag);
    chk(tag, {32'd0, o_dat}, {32'd0, d});
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_dat = '0;
    o_rdy = 1'b0;
    tick();
    tick();
    chk("rst_i_rdy",   {63'd0, i_rdy},   64'd0);
    chk("rst_o_vld",   {63'd0, o_vld},   64'd0);
    chk("rst_o_dat",   {32'd0, o_dat},   64'd0);
    chk("rst_o_count", {61'd0, o_count}, 64'd0);
`ifdef CDC_RX_BUF_PROTO_CHK_EN
    chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: single transfer, ack three edges after request rise
    o_rdy = 1'b1;
    i_dat = 32'hA5A5_0001;
    i_vld = 1'b1;
    tick();
    tick();
    chk("t1_rdy_early", {63'd0, i_rdy}, 64'd0);
    chk("t1_vld_early", {63'd0, o_vld}, 64'd0);
    tick();
    chk("t1_rdy",   {63'd0, i_rdy},   64'd1);
    chk("t1_vld",   {63'd0, o_vld},   64'd1);
    chk("t1_dat",   {32'd0, o_dat},   64'hA5A5_0001);
    chk("t1_count", {61'd0, o_count}, 64'd1);
    tick();
    chk("t1_popped", {61'd0, o_count}, 64'd0);
    i_vld = 1'b0;
    tick();
    tick();
    chk("t1_rdy_hold", {63'd0, i_rdy}, 64'd1);
    tick();
    chk("t1_rdy_fall", {63'd0, i_rdy}, 64'd0);
    o_rdy = 1'b0;

    // 2: back-pressure, fifth request stalls until a slot frees
    for (int d = 1; d <= 4; d++) handshake(32'(d));
    chk("t2_full", {61'd0, o_count}, 64'd4);
    i_dat = 32'd5;
    i_vld = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("t2_stall_rdy", {63'd0, i_rdy},   64'd0);
    chk("t2_stall_cnt", {61'd0, o_count}, 64'd4);
    chk("t2_head1",     {32'd0, o_dat},   64'd1);
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("t2_pop_cnt", {61'd0, o_count}, 64'd3);
    chk("t2_head2",   {32'd0, o_dat},   64'd2);
    chk("t2_pop_rdy", {63'd0, i_rdy},   64'd0);
    tick();
    chk("t2_ack5", {63'd0, i_rdy},   64'd1);
    chk("t2_cnt4", {61'd0, o_count}, 64'd4);
    i_vld = 1'b0;
    wait_rdy(1'b0, "t2_ack5_fall");
    for (int d = 2; d <= 5; d++) drain_one(32'(d), "t2_drain");
    chk("t2_empty", {63'd0, o_vld}, 64'd0);

    // 3: push and pop on the same edge
    handshake(32'd1);
    handshake(32'd2);
    chk("t3_cnt2", {61'd0, o_count}, 64'd2);
    i_dat = 32'd3;
    i_vld = 1'b1;
    tick();
    tick();
    chk("t3_head1", {32'd0, o_dat}, 64'd1);
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("t3_ack",    {63'd0, i_rdy},   64'd1);
    chk("t3_cnt",    {61'd0, o_count}, 64'd2);
    chk("t3_head2",  {32'd0, o_dat},   64'd2);
    i_vld = 1'b0;
    wait_rdy(1'b0, "t3_fall");
    drain_one(32'd2, "t3_order");
    drain_one(32'd3, "t3_order");
    chk("t3_empty", {61'd0, o_count}, 64'd0);

    // 4: ten transfers against a random consumer, across pointer wrap
    exp_d = 1;
    fork
      begin
        for (int d = 1; d <= 10; d++) handshake(32'(d));
      end
      begin
        for (int k = 0; k < 600 && exp_d <= 10; k++) begin
          o_rdy = 1'($urandom_range(0, 1));
          if (o_vld && o_rdy) begin
            chk("t4_order", {32'd0, o_dat}, 64'(exp_d));
            exp_d++;
          end
          chk("t4_cnt_le4", {63'd0, (o_count <= 3'd4)}, 64'd1);
          tick();
        end
        o_rdy = 1'b0;
      end
    join
    chk("t4_all_seen", 64'(exp_d), 64'd11);
    chk("t4_empty",    {61'd0, o_count}, 64'd0);

    // 5: reset with three entries held and an ack outstanding
    handshake(32'h11);
    handshake(32'h22);
    i_dat = 32'h33;
    i_vld = 1'b1;
    wait_rdy(1'b1, "t5_ack");
    chk("t5_cnt3", {61'd0, o_count}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy", {63'd0, i_rdy},   64'd0);
    chk("t5_rst_vld", {63'd0, o_vld},   64'd0);
    chk("t5_rst_dat", {32'd0, o_dat},   64'd0);
    chk("t5_rst_cnt", {61'd0, o_count}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_recap_early", {63'd0, i_rdy}, 64'd0);
    tick();
    chk("t5_recap_rdy", {63'd0, i_rdy},   64'd1);
    chk("t5_recap_cnt", {61'd0, o_count}, 64'd1);
    chk("t5_recap_dat", {32'd0, o_dat},   64'h33);
    i_vld = 1'b0;
    wait_rdy(1'b0, "t5_fall");
    drain_one(32'h33, "t5_drain");
    chk("t5_empty", {61'd0, o_count}, 64'd0);

    // 6: request withdrawn while the FIFO is full
    for (int d = 'h61; d <= 'h64; d++) handshake(32'(d));
    chk("t6_full", {61'd0, o_count}, 64'd4);
`ifdef CDC_RX_BUF_PROTO_CHK_EN
    chk("t6_err_before", {63'd0, proto_err}, 64'd0);
`endif
    i_dat = 32'hDEAD;
    i_vld = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    i_vld = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t6_cnt",  {61'd0, o_count}, 64'd4);
    chk("t6_rdy",  {63'd0, i_rdy},   64'd0);
    chk("t6_head", {32'd0, o_dat},   64'h61);
`ifdef CDC_RX_BUF_PROTO_CHK_EN
    chk("t6_err_set", {63'd0, proto_err}, 64'd1);
`endif
    for (int d = 'h61; d <= 'h64; d++) drain_one(32'(d), "t6_drain");
    chk("t6_empty", {61'd0, o_count}, 64'd0);
`ifdef CDC_RX_BUF_PROTO_CHK_EN
    chk("t6_err_sticky", {63'd0, proto_err}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
